vec_alu_arbiter: RTL

//  Shares one VecALU between two requesters (e.g. vector issue port and duplex/broadcast unit).

---
 rtl/vec_alu_pkg.sv | 25 ++
 rtl/vec_alu_arbiter_valu.sv | 30 +++
 rtl/vec_alu_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/vec_alu_pkg.sv
// rtl/vec_alu_pkg.sv - opcode and arbiter-state types shared by the vector ALU slice
package vec_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_MOV    = 3'b010,
    OP_MUL    = 3'b011,
    OP_DIV    = 3'b100,
    OP_RSV5   = 3'b101,
    OP_RSV6   = 3'b110,
    OP_DUPLEX = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  function automatic logic is_valid_op(input logic [2:0] op);
    return !((op == OP_RSV5) || (op == OP_RSV6));
  endfunction

endpackage

// File: rtl/vec_alu_arbiter_valu.sv
// rtl/vec_alu_arbiter_valu.sv - combinational per-lane vector ALU (VecALU)
module VecALU
  import vec_alu_pkg::*;
#(
  parameter int LANES = 16,
  parameter int WIDTH = 16
) (
  input  logic [LANES-1:0][WIDTH-1:0] A,
  input  logic [LANES-1:0][WIDTH-1:0] B,
  input  logic [2:0]                  Operation,
  output logic [LANES-1:0][WIDTH-1:0] Result
);

  always_comb begin
    Result = '0;
    for (int i = 0; i < LANES; i++) begin
      case (alu_op_e'(Operation))
        OP_ADD:    Result[i] = A[i] + B[i];
        OP_SUB:    Result[i] = A[i] - B[i];
        OP_MOV:    Result[i] = B[i];
        OP_MUL:    Result[i] = A[i] * B[i];
        // Divide by zero saturates to all ones rather than producing X.
        OP_DIV:    Result[i] = (B[i] == '0) ? '1 : A[i] / B[i];
        OP_DUPLEX: Result[i] = A[i/2];
        default:   Result[i] = '0;
      endcase
    end
  end

endmodule

// File: rtl/vec_alu_arbiter.sv
// rtl/vec_alu_arbiter.sv - round-robin sharing of one VecALU between two requesters
module vec_alu_arbiter
  import vec_alu_pkg::*;
#(
  parameter int LANES   = 16,
  parameter int WIDTH   = 16,
  parameter int DIV_LAT = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [1:0]                       req_valid,
  output logic [1:0]                       req_ready,
  input  logic [1:0][LANES-1:0][WIDTH-1:0] req_a,
  input  logic [1:0][LANES-1:0][WIDTH-1:0] req_b,
  input  logic [1:0][2:0]                  req_op,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic                             res_id,
  output logic [LANES-1:0][WIDTH-1:0]      res_data,
  output logic                             res_err,
  output logic                             busy
);

  localparam int CW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  arb_state_e                  state, state_nxt;
  logic                        rr_ptr;
  logic                        grant_any, grant_id;
  logic                        accept, exec_done, res_fire;
  logic                        lat_id;
  logic [2:0]                  lat_op;
  logic [LANES-1:0][WIDTH-1:0] lat_a, lat_b, alu_res;
  logic [CW-1:0]               cnt;

  // rr_ptr holds priority; the other requester only wins when rr_ptr is idle.
  assign grant_any = |req_valid;
  assign grant_id  = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
  assign accept    = (state == IDLE) && grant_any;
  assign exec_done = (state == EXEC) &&
                     ((lat_op != OP_DIV) || (cnt == CW'(DIV_LAT - 1)));
  assign res_fire  = (state == DONE) && res_ready;

  VecALU #(.LANES(LANES), .WIDTH(WIDTH)) u_valu (
    .A        (lat_a),
    .B        (lat_b),
    .Operation(lat_op),
    .Result   (alu_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = EXEC;
      EXEC:    if (exec_done) state_nxt = DONE;
      DONE:    if (res_fire)  state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (grant_any) req_ready[grant_id] = 1'b1;
      end
      DONE:    res_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= 1'b0;
      lat_id   <= 1'b0;
      lat_op   <= '0;
      lat_a    <= '0;
      lat_b    <= '0;
      cnt      <= '0;
      res_id   <= 1'b0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      if (accept) begin
        lat_a  <= req_a[grant_id];
        lat_b  <= req_b[grant_id];
        lat_op <= req_op[grant_id];
        lat_id <= grant_id;
        cnt    <= '0;
      end
      if (state == EXEC) cnt <= cnt + 1'b1;
      // The ALU already yields zero for reserved opcodes; only the error flag is added.
      if (exec_done) begin
        res_data <= alu_res;
        res_err  <= !is_valid_op(lat_op);
        res_id   <= lat_id;
      end
      if (res_fire) rr_ptr <= ~lat_id;
    end
  end

endmodule
